// File: rtl/ping_pong_ctrl_w_pkg.sv
// Shared types and derived sizing for the west ping-pong buffer controller.
package ping_pong_ctrl_w_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  typedef enum logic {
    W_IDLE  = 1'b0,
    W_SLICE = 1'b1
  } wr_fsm_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } rd_fsm_e;

  typedef enum logic [1:0] {
    DRV_NONE  = 2'd0,
    DRV_WRITE = 2'd1,
    DRV_READ  = 2'd2
  } port_drive_e;

  localparam int unsigned DEF_TOTAL_MODULES = 4;
  localparam int unsigned DEF_COL_X         = 16;
  localparam int unsigned DEF_TOTAL_INPUT_W = 2;

  function automatic int unsigned calc_beats_per_bank(input int unsigned depth,
                                                      input int unsigned modules);
    return depth / (2 * modules);
  endfunction

  function automatic int unsigned calc_pairs_per_bank(input int unsigned depth);
    return depth / 2;
  endfunction

  localparam int unsigned BEATS_PER_BANK =
    calc_beats_per_bank(DEF_COL_X * DEF_TOTAL_INPUT_W, DEF_TOTAL_MODULES);
  localparam int unsigned PAIRS_PER_BANK =
    calc_pairs_per_bank(DEF_COL_X * DEF_TOTAL_INPUT_W);

endpackage

// File: rtl/ping_pong_ctrl_w_bank_port_mux.sv
// Per-bank RAM port driver: the owning side (writer or reader) drives both ports.
module pp_bank_port_mux
  import ping_pong_ctrl_w_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  wr_own,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addra,
  input  logic [ADDR_WIDTH-1:0] wr_addrb,
  input  logic                  rd_own,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addra,
  input  logic [ADDR_WIDTH-1:0] rd_addrb,
  output logic                  ena,
  output logic                  enb,
  output logic                  wea,
  output logic                  web,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [ADDR_WIDTH-1:0] addrb
);

  port_drive_e drive;

  always_comb begin
    drive = DRV_NONE;
    if (wr_own && wr_en) begin
      drive = DRV_WRITE;
    end else if (rd_own && rd_en) begin
      drive = DRV_READ;
    end
  end

  always_comb begin
    ena   = 1'b0;
    enb   = 1'b0;
    wea   = 1'b0;
    web   = 1'b0;
    addra = '0;
    addrb = '0;
    case (drive)
      DRV_WRITE: begin
        ena   = 1'b1;
        enb   = 1'b1;
        wea   = 1'b1;
        web   = 1'b1;
        addra = wr_addra;
        addrb = wr_addrb;
      end
      DRV_READ: begin
        ena   = 1'b1;
        enb   = 1'b1;
        addra = rd_addra;
        addrb = rd_addrb;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ping_pong_ctrl_w.sv
// Two-bank west ping-pong buffer sequencer: producer slices fill one bank while
// the matmul consumer drains the other as address pairs.
//
// state    | meaning
// W_IDLE   | no beat in progress, or waiting for bank[wr_sel] to be EMPTY
// W_SLICE  | writing one module slice per cycle through both RAM ports
// R_IDLE   | waiting for bank[rd_sel] to become FULL
// R_READ   | issuing address pairs of bank[out_bank_sel] under valid/ready
module ping_pong_ctrl_w
  import ping_pong_ctrl_w_pkg::*;
#(
  parameter int unsigned TOTAL_MODULES = DEF_TOTAL_MODULES,
  parameter int unsigned COL_X         = DEF_COL_X,
  parameter int unsigned TOTAL_INPUT_W = DEF_TOTAL_INPUT_W,
  localparam int unsigned TOTAL_DEPTH  = COL_X * TOTAL_INPUT_W,
  localparam int unsigned ADDR_WIDTH   = $clog2(TOTAL_DEPTH),
  localparam int unsigned SLICE_W      = $clog2(TOTAL_MODULES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [SLICE_W-1:0]    slicing_idx,
  output logic                  bank0_ena,
  output logic                  bank0_enb,
  output logic                  bank0_wea,
  output logic                  bank0_web,
  output logic [ADDR_WIDTH-1:0] bank0_addra,
  output logic [ADDR_WIDTH-1:0] bank0_addrb,
  output logic                  bank1_ena,
  output logic                  bank1_enb,
  output logic                  bank1_wea,
  output logic                  bank1_web,
  output logic [ADDR_WIDTH-1:0] bank1_addra,
  output logic [ADDR_WIDTH-1:0] bank1_addrb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  out_bank_sel,
  output logic [1:0]            bank_full
);

  localparam int unsigned BEATS  = calc_beats_per_bank(TOTAL_DEPTH, TOTAL_MODULES);
  localparam int unsigned PAIRS  = calc_pairs_per_bank(TOTAL_DEPTH);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PAIR_W = $clog2(PAIRS) + 1;

  if (TOTAL_DEPTH % (2 * TOTAL_MODULES) != 0) begin : g_bad_beats
    $error("ping_pong_ctrl_w: TOTAL_DEPTH must be a multiple of 2*TOTAL_MODULES");
  end
  if (TOTAL_INPUT_W != 2) begin : g_bad_input_w
    $error("ping_pong_ctrl_w: TOTAL_INPUT_W must be 2 (one word per RAM port)");
  end

  bank_state_e bank_st [2];

  // write side
  wr_fsm_e               wr_state, wr_state_d;
  logic                  wr_sel;
  logic [SLICE_W-1:0]    slice_cnt;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr_b;
  logic                  wr_active;
  logic                  slice_last;
  logic                  bank_done;
  logic                  wr_bank_avail;
  logic                  next_bank_empty;

  // read side
  rd_fsm_e               rd_state, rd_state_d;
  logic                  rd_sel;
  logic [PAIR_W-1:0]     pairs_issued;
  logic [ADDR_WIDTH-1:0] rd_addra;
  logic [ADDR_WIDTH-1:0] rd_addrb;
  logic                  rd_issue;
  logic                  rd_accept;
  logic                  rd_start;
  logic                  rd_free;

  assign wr_active       = (wr_state == W_SLICE) && in_valid;
  assign slice_last      = (slice_cnt == SLICE_W'(TOTAL_MODULES - 1));
  assign bank_done       = slice_last && (beat_cnt == BEAT_W'(BEATS - 1));
  assign wr_bank_avail   = (bank_st[wr_sel] == BANK_EMPTY) || (bank_st[wr_sel] == BANK_FILLING);
  assign next_bank_empty = (bank_st[~wr_sel] == BANK_EMPTY);
  assign wr_ptr_b        = wr_ptr + ADDR_WIDTH'(1);

  assign in_ready    = wr_active && slice_last;
  assign slicing_idx = slice_cnt;

  always_comb begin
    wr_state_d = wr_state;
    case (wr_state)
      W_IDLE: begin
        if (in_valid && wr_bank_avail) wr_state_d = W_SLICE;
      end
      W_SLICE: begin
        // A gap between beats parks the writer; a full bank with a busy
        // partner parks it until the reader frees that partner.
        if (!in_valid) begin
          wr_state_d = W_IDLE;
        end else if (bank_done && !next_bank_empty) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= W_IDLE;
      wr_sel    <= 1'b0;
      slice_cnt <= '0;
      beat_cnt  <= '0;
      wr_ptr    <= '0;
    end else begin
      wr_state <= wr_state_d;
      if (wr_active) begin
        if (slice_last) begin
          slice_cnt <= '0;
          if (bank_done) begin
            beat_cnt <= '0;
            wr_ptr   <= '0;
            wr_sel   <= ~wr_sel;
          end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            wr_ptr   <= wr_ptr + ADDR_WIDTH'(2);
          end
        end else begin
          slice_cnt <= slice_cnt + SLICE_W'(1);
          wr_ptr    <= wr_ptr + ADDR_WIDTH'(2);
        end
      end
    end
  end

  assign rd_addra  = {pairs_issued[ADDR_WIDTH-2:0], 1'b0};
  assign rd_addrb  = {pairs_issued[ADDR_WIDTH-2:0], 1'b1};
  assign rd_accept = out_valid && out_ready;
  assign rd_start  = (rd_state == R_IDLE) && (bank_st[rd_sel] == BANK_FULL);
  assign rd_issue  = (rd_state == R_READ) && (pairs_issued < PAIR_W'(PAIRS)) &&
                     (!out_valid || out_ready);
  assign rd_free   = (rd_state == R_READ) && rd_accept && out_last;

  always_comb begin
    rd_state_d = rd_state;
    case (rd_state)
      R_IDLE:  if (rd_start) rd_state_d = R_READ;
      R_READ:  if (rd_free)  rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state     <= R_IDLE;
      rd_sel       <= 1'b0;
      out_bank_sel <= 1'b0;
      pairs_issued <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      rd_state <= rd_state_d;
      if (rd_start) begin
        out_bank_sel <= rd_sel;
        pairs_issued <= '0;
      end
      // RAM read latency is one cycle, so valid/last follow the issue.
      if (rd_issue) begin
        pairs_issued <= pairs_issued + PAIR_W'(1);
        out_valid    <= 1'b1;
        out_last     <= (pairs_issued == PAIR_W'(PAIRS - 1));
      end else if (rd_accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (rd_free) begin
        rd_sel       <= ~rd_sel;
        pairs_issued <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_active && (wr_sel == 1'(i))) begin
          if (bank_done) begin
            bank_st[i] <= BANK_FULL;
          end else if (bank_st[i] == BANK_EMPTY) begin
            bank_st[i] <= BANK_FILLING;
          end
        end
        if (rd_start && (rd_sel == 1'(i))) begin
          bank_st[i] <= BANK_DRAINING;
        end
        if (rd_free && (out_bank_sel == 1'(i))) begin
          bank_st[i] <= BANK_EMPTY;
        end
      end
    end
  end

  assign bank_full = {bank_st[1] == BANK_FULL, bank_st[0] == BANK_FULL};

  pp_bank_port_mux #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank0_mux (
    .wr_own   (wr_sel == 1'b0),
    .wr_en    (wr_active),
    .wr_addra (wr_ptr),
    .wr_addrb (wr_ptr_b),
    .rd_own   ((rd_state == R_READ) && (out_bank_sel == 1'b0)),
    .rd_en    (rd_issue),
    .rd_addra (rd_addra),
    .rd_addrb (rd_addrb),
    .ena      (bank0_ena),
    .enb      (bank0_enb),
    .wea      (bank0_wea),
    .web      (bank0_web),
    .addra    (bank0_addra),
    .addrb    (bank0_addrb)
  );

  pp_bank_port_mux #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank1_mux (
    .wr_own   (wr_sel == 1'b1),
    .wr_en    (wr_active),
    .wr_addra (wr_ptr),
    .wr_addrb (wr_ptr_b),
    .rd_own   ((rd_state == R_READ) && (out_bank_sel == 1'b1)),
    .rd_en    (rd_issue),
    .rd_addra (rd_addra),
    .rd_addrb (rd_addrb),
    .ena      (bank1_ena),
    .enb      (bank1_enb),
    .wea      (bank1_wea),
    .web      (bank1_web),
    .addra    (bank1_addra),
    .addrb    (bank1_addrb)
  );

  // Write enables of a bank must only come from the writer owning that bank.
  a_bank1_web_owner : assert property (@(posedge clk) disable iff (rst)
    bank1_web |-> wr_sel);
  a_bank0_web_owner : assert property (@(posedge clk) disable iff (rst)
    bank0_web |-> !wr_sel);
  a_no_shared_bank : assert property (@(posedge clk) disable iff (rst)
    !(wr_active && rd_issue && (out_bank_sel == wr_sel)));

endmodule

// File: tb/tb_ping_pong_ctrl_w.sv
// Directed bench for ping_pong_ctrl_w: fill, drain with backpressure, overlap,
// writer stall on a busy bank, and mid-fill reset.
module tb_ping_pong_ctrl_w;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] slicing_idx;
  logic       bank0_ena, bank0_enb, bank0_wea, bank0_web;
  logic [4:0] bank0_addra, bank0_addrb;
  logic       bank1_ena, bank1_enb, bank1_wea, bank1_web;
  logic [4:0] bank1_addra, bank1_addrb;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       out_bank_sel;
  logic [1:0] bank_full;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ping_pong_ctrl_w dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .slicing_idx  (slicing_idx),
    .bank0_ena    (bank0_ena),
    .bank0_enb    (bank0_enb),
    .bank0_wea    (bank0_wea),
    .bank0_web    (bank0_web),
    .bank0_addra  (bank0_addra),
    .bank0_addrb  (bank0_addrb),
    .bank1_ena    (bank1_ena),
    .bank1_enb    (bank1_enb),
    .bank1_wea    (bank1_wea),
    .bank1_web    (bank1_web),
    .bank1_addra  (bank1_addra),
    .bank1_addrb  (bank1_addrb),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .out_bank_sel (out_bank_sel),
    .bank_full    (bank_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int  pres;
    int  nxt;
    int  m;
    bit  iss;
    bit  wr;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    @(negedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_slicing_idx", slicing_idx, 0);
    chk("rst_bank0_ena", bank0_ena, 0);
    chk("rst_bank1_ena", bank1_ena, 0);
    chk("rst_bank0_wea", bank0_wea, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_bank_sel", out_bank_sel, 0);
    chk("rst_bank_full", bank_full, 2'b00);

    // claim cycle: writer leaves idle, no port activity yet
    @(negedge clk); rst = 1'b0; in_valid = 1'b1; #1;
    chk("claim_bank0_ena", bank0_ena, 0);
    chk("claim_in_ready", in_ready, 0);

    // single fill of bank0: 4 beats x 4 slices
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      chk($sformatf("fill_ena_%0d", k), bank0_ena, 1);
      chk($sformatf("fill_enb_%0d", k), bank0_enb, 1);
      chk($sformatf("fill_wea_%0d", k), bank0_wea, 1);
      chk($sformatf("fill_web_%0d", k), bank0_web, 1);
      chk($sformatf("fill_addra_%0d", k), bank0_addra, 2 * k);
      chk($sformatf("fill_addrb_%0d", k), bank0_addrb, 2 * k + 1);
      chk($sformatf("fill_slice_%0d", k), slicing_idx, k % 4);
      chk($sformatf("fill_in_ready_%0d", k), in_ready, (k % 4) == 3);
      chk($sformatf("fill_bank1_ena_%0d", k), bank1_ena, 0);
    end

    // producer pauses; bank0 now FULL, reader starts this cycle
    @(negedge clk); in_valid = 1'b0; #1;
    chk("full_bank_full", bank_full, 2'b01);
    chk("full_bank0_ena", bank0_ena, 0);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 0);

    // drain bank0 (ready low for 5 cycles) while the producer fills bank1
    pres = -1;
    nxt  = 0;
    for (int j = 0; j < 22; j++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = (j < 8) || (j > 12);
      #1;
      iss = (nxt < 16) && ((pres < 0) || out_ready);
      wr  = (j >= 1) && (j <= 16);
      chk($sformatf("drain_ena_%0d", j), bank0_ena, iss);
      chk($sformatf("drain_enb_%0d", j), bank0_enb, iss);
      chk($sformatf("drain_wea_%0d", j), bank0_wea, 0);
      chk($sformatf("drain_web_%0d", j), bank0_web, 0);
      if (iss) begin
        chk($sformatf("drain_addra_%0d", j), bank0_addra, 2 * nxt);
        chk($sformatf("drain_addrb_%0d", j), bank0_addrb, 2 * nxt + 1);
      end
      chk($sformatf("drain_valid_%0d", j), out_valid, pres >= 0);
      chk($sformatf("drain_last_%0d", j), out_last, pres == 15);
      chk($sformatf("drain_bank_sel_%0d", j), out_bank_sel, 0);
      chk($sformatf("ovl_b1_wea_%0d", j), bank1_wea, wr);
      chk($sformatf("ovl_b1_ena_%0d", j), bank1_ena, wr);
      if (wr) begin
        chk($sformatf("ovl_b1_addra_%0d", j), bank1_addra, 2 * (j - 1));
        chk($sformatf("ovl_b1_addrb_%0d", j), bank1_addrb, 2 * (j - 1) + 1);
      end
      chk($sformatf("ovl_in_ready_%0d", j), in_ready, wr && (((j - 1) % 4) == 3));
      chk($sformatf("ovl_bank_full_%0d", j), bank_full, (j >= 17) ? 2'b10 : 2'b00);
      if (iss) begin
        pres = nxt;
        nxt++;
      end else if (out_ready && (pres >= 0)) begin
        pres = -1;
      end
    end

    // bank0 freed last cycle: writer sees EMPTY now, reader claims bank1
    @(negedge clk); out_ready = 1'b1; #1;
    chk("stall_in_ready", in_ready, 0);
    chk("stall_bank_full", bank_full, 2'b10);
    chk("stall_out_valid", out_valid, 0);
    chk("stall_bank0_ena", bank0_ena, 0);
    chk("stall_bank1_ena", bank1_ena, 0);

    // resume: write bank0 from addr 0 while bank1 drains
    @(negedge clk); #1;
    chk("resume_b0_wea", bank0_wea, 1);
    chk("resume_b0_addra", bank0_addra, 0);
    chk("resume_b0_addrb", bank0_addrb, 1);
    chk("resume_slice", slicing_idx, 0);
    chk("resume_b1_ena", bank1_ena, 1);
    chk("resume_b1_wea", bank1_wea, 0);
    chk("resume_b1_web", bank1_web, 0);
    chk("resume_b1_addra", bank1_addra, 0);
    chk("resume_b1_addrb", bank1_addrb, 1);
    chk("resume_bank_sel", out_bank_sel, 1);
    chk("resume_bank_full", bank_full, 2'b00);
    chk("resume_out_valid", out_valid, 0);

    for (int j = 24; j < 31; j++) begin
      @(negedge clk); #1;
      m = j - 23;
      chk($sformatf("refill_wea_%0d", j), bank0_wea, 1);
      chk($sformatf("refill_addra_%0d", j), bank0_addra, 2 * m);
      chk($sformatf("refill_slice_%0d", j), slicing_idx, m % 4);
      chk($sformatf("refill_in_ready_%0d", j), in_ready, (m % 4) == 3);
      chk($sformatf("refill_b1_wea_%0d", j), bank1_wea, 0);
      chk($sformatf("refill_b1_addra_%0d", j), bank1_addra, 2 * m);
      chk($sformatf("refill_valid_%0d", j), out_valid, 1);
    end

    // reset after two beats of the bank0 refill
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_slice", slicing_idx, 0);
    chk("mrst_bank0_ena", bank0_ena, 0);
    chk("mrst_bank1_ena", bank1_ena, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_last", out_last, 0);
    chk("mrst_bank_sel", out_bank_sel, 0);
    chk("mrst_bank_full", bank_full, 2'b00);

    @(negedge clk); #1;
    chk("post_rst_b0_wea", bank0_wea, 1);
    chk("post_rst_b0_addra", bank0_addra, 0);
    chk("post_rst_slice", slicing_idx, 0);
    chk("post_rst_b1_ena", bank1_ena, 0);

    @(negedge clk); #1;
    chk("post_rst_b0_addra2", bank0_addra, 2);
    chk("post_rst_slice2", slicing_idx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
